// File: rtl/lsd_gradient_pkg.sv
// Shared definitions for the LSD gradient stage: width helpers and octant codes.
package lsd_gradient_pkg;

  // Orientation octants, counter-clockwise starting from +gx.
  typedef enum logic [2:0] {
    DIR_0 = 3'd0,
    DIR_1 = 3'd1,
    DIR_2 = 3'd2,
    DIR_3 = 3'd3,
    DIR_4 = 3'd4,
    DIR_5 = 3'd5,
    DIR_6 = 3'd6,
    DIR_7 = 3'd7
  } dir_t;

  // Sum of four pixels needs two extra bits; the signed difference fits as well.
  localparam int MAG_GROWTH = 2;

  // Rows that must have been written since reset before outputs can be valid.
  localparam logic [1:0] ROWS_PRIMED = 2'd2;

  // Ceiling log2, never below 1 so it can size a counter port.
  function automatic int lsd_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Octant from gradient signs and the |gx| vs |gy| comparison.
  function automatic dir_t octant(input logic gx_neg, input logic gy_neg,
                                  input logic ax_gt_ay, input logic both_zero);
    if (both_zero) return DIR_0;
    case ({gx_neg, gy_neg})
      2'b00:   return ax_gt_ay ? DIR_0 : DIR_1;
      2'b10:   return ax_gt_ay ? DIR_3 : DIR_2;
      2'b11:   return ax_gt_ay ? DIR_4 : DIR_5;
      default: return ax_gt_ay ? DIR_7 : DIR_6;
    endcase
  endfunction

endpackage

// File: rtl/lsd_gradient_coord_adjuster.sv
// Delays the frame coordinates so they stay aligned with the pixel pipeline.
module coord_adjuster #(
  parameter int V_BITW  = 10,
  parameter int H_BITW  = 10,
  parameter int LATENCY = 3
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [V_BITW-1:0] in_vcnt,
  input  logic [H_BITW-1:0] in_hcnt,
  output logic [V_BITW-1:0] out_vcnt,
  output logic [H_BITW-1:0] out_hcnt
);

  logic [V_BITW-1:0] v_pipe_reg [0:LATENCY-1];
  logic [H_BITW-1:0] h_pipe_reg [0:LATENCY-1];

  // Shift register of coordinates; cleared so outputs read 0 until fresh inputs arrive.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        v_pipe_reg[i] <= '0;
        h_pipe_reg[i] <= '0;
      end
    end else begin
      v_pipe_reg[0] <= in_vcnt;
      h_pipe_reg[0] <= in_hcnt;
      for (int i = 1; i < LATENCY; i++) begin
        v_pipe_reg[i] <= v_pipe_reg[i-1];
        h_pipe_reg[i] <= h_pipe_reg[i-1];
      end
    end
  end

  assign out_vcnt = v_pipe_reg[LATENCY-1];
  assign out_hcnt = h_pipe_reg[LATENCY-1];

endmodule

// File: rtl/lsd_gradient_line_buffer.sv
// One-row line buffer: single-port RAM, read-before-write, 1-cycle read latency.
module line_buffer #(
  parameter int DEPTH  = 800,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Old contents come out while the new pixel replaces them; no reset so it maps to block RAM.
  always_ff @(posedge clock) begin
    rd_data   <= mem[addr];
    mem[addr] <= wr_data;
  end

endmodule

// File: rtl/lsd_gradient.sv
// Streaming 2x2 gradient: magnitude, octant and valid flag, fixed 3-cycle latency.
module lsd_gradient
  import lsd_gradient_pkg::*;
#(
  parameter int BIT_WIDTH    = 8,
  parameter int IMAGE_HEIGHT = 480,
  parameter int IMAGE_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 525,
  parameter int FRAME_WIDTH  = 800,
  parameter int MAG_THRESH   = 16,
  localparam int V_BITW      = lsd_log2(FRAME_HEIGHT),
  localparam int H_BITW      = lsd_log2(FRAME_WIDTH),
  localparam int MAG_BITW    = BIT_WIDTH + MAG_GROWTH
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] in_pixel,
  input  logic [V_BITW-1:0]    in_vcnt,
  input  logic [H_BITW-1:0]    in_hcnt,
  output logic [MAG_BITW-1:0]  out_mag,
  output logic [2:0]           out_dir,
  output logic                 out_valid,
  output logic [V_BITW-1:0]    out_vcnt,
  output logic [H_BITW-1:0]    out_hcnt
);

  localparam logic [V_BITW-1:0]   IMG_H  = V_BITW'(IMAGE_HEIGHT);
  localparam logic [H_BITW-1:0]   IMG_W  = H_BITW'(IMAGE_WIDTH);
  localparam logic [MAG_BITW-1:0] THRESH = MAG_BITW'(MAG_THRESH);

  logic [BIT_WIDTH-1:0]       b_data;
  logic [BIT_WIDTH-1:0]       a_reg, c_reg, d_reg;
  logic [1:0]                 row_cnt_reg;
  logic                       mask1_reg, mask2_reg;
  logic signed [MAG_BITW-1:0] gx_reg, gy_reg;
  logic signed [MAG_BITW-1:0] a_s, b_s, c_s, d_s, gx_next, gy_next;
  logic [MAG_BITW-1:0]        ax, ay, mag_next;
  logic                       in_window;
  dir_t                       dir_next;

  line_buffer #(
    .DEPTH (FRAME_WIDTH),
    .WIDTH (BIT_WIDTH),
    .ADDR_W(H_BITW)
  ) u_line_buffer (
    .clock  (clock),
    .addr   (in_hcnt),
    .wr_data(in_pixel),
    .rd_data(b_data)
  );

  coord_adjuster #(
    .V_BITW (V_BITW),
    .H_BITW (H_BITW),
    .LATENCY(3)
  ) u_coord_adjuster (
    .clock   (clock),
    .rst     (rst),
    .in_vcnt (in_vcnt),
    .in_hcnt (in_hcnt),
    .out_vcnt(out_vcnt),
    .out_hcnt(out_hcnt)
  );

  // Column 0 and row 0 are excluded, which also hides stale A/C after an hcnt wrap.
  assign in_window = (in_vcnt != '0) && (in_hcnt != '0) &&
                     (in_vcnt < IMG_H) && (in_hcnt < IMG_W);

  // Stage 1: capture D, qualify the window and count rows seen since reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      d_reg       <= '0;
      mask1_reg   <= 1'b0;
      row_cnt_reg <= '0;
    end else begin
      d_reg     <= in_pixel;
      mask1_reg <= in_window && (row_cnt_reg == ROWS_PRIMED);
      if (in_hcnt == '0 && row_cnt_reg != ROWS_PRIMED)
        row_cnt_reg <= row_cnt_reg + 2'd1;
    end
  end

  assign a_s = signed'({{MAG_GROWTH{1'b0}}, a_reg});
  assign b_s = signed'({{MAG_GROWTH{1'b0}}, b_data});
  assign c_s = signed'({{MAG_GROWTH{1'b0}}, c_reg});
  assign d_s = signed'({{MAG_GROWTH{1'b0}}, d_reg});

  assign gx_next = (b_s + d_s) - (a_s + c_s);
  assign gy_next = (c_s + d_s) - (a_s + b_s);

  // Stage 2: keep last B/D as the left column and register the raw gradients.
  always_ff @(posedge clock) begin
    if (rst) begin
      a_reg     <= '0;
      c_reg     <= '0;
      gx_reg    <= '0;
      gy_reg    <= '0;
      mask2_reg <= 1'b0;
    end else begin
      a_reg     <= b_data;
      c_reg     <= d_reg;
      gx_reg    <= gx_next;
      gy_reg    <= gy_next;
      mask2_reg <= mask1_reg;
    end
  end

  assign ax       = gx_reg[MAG_BITW-1] ? MAG_BITW'(-gx_reg) : MAG_BITW'(gx_reg);
  assign ay       = gy_reg[MAG_BITW-1] ? MAG_BITW'(-gy_reg) : MAG_BITW'(gy_reg);
  assign mag_next = ax + ay;
  assign dir_next = octant(gx_reg[MAG_BITW-1], gy_reg[MAG_BITW-1], ax > ay,
                           (gx_reg == '0) && (gy_reg == '0));

  // Stage 3: magnitude and octant, forced to zero outside the usable window.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_mag   <= '0;
      out_dir   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_mag   <= mask2_reg ? mag_next : '0;
      out_dir   <= mask2_reg ? dir_next : DIR_0;
      out_valid <= mask2_reg && (mag_next >= THRESH);
    end
  end

endmodule

// File: tb/tb_lsd_gradient.sv
// Scoreboard bench for lsd_gradient on a small 10x8 frame with an 8x6 active image.
module tb_lsd_gradient;

  localparam int BW = 8;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int FW = 10;
  localparam int FH = 8;
  localparam int TH = 16;
  localparam int VB = 3;
  localparam int HB = 4;
  localparam int MB = BW + 2;

  logic          clock = 1'b0;
  logic          rst;
  logic [BW-1:0] in_pixel;
  logic [VB-1:0] in_vcnt;
  logic [HB-1:0] in_hcnt;
  logic [MB-1:0] out_mag;
  logic [2:0]    out_dir;
  logic          out_valid;
  logic [VB-1:0] out_vcnt;
  logic [HB-1:0] out_hcnt;

  lsd_gradient #(
    .BIT_WIDTH   (BW),
    .IMAGE_HEIGHT(IH),
    .IMAGE_WIDTH (IW),
    .FRAME_HEIGHT(FH),
    .FRAME_WIDTH (FW),
    .MAG_THRESH  (TH)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .in_pixel (in_pixel),
    .in_vcnt  (in_vcnt),
    .in_hcnt  (in_hcnt),
    .out_mag  (out_mag),
    .out_dir  (out_dir),
    .out_valid(out_valid),
    .out_vcnt (out_vcnt),
    .out_hcnt (out_hcnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int mag;
    int dir;
    int valid;
    int v;
    int h;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [2:0] rst_sh = 3'b111;
  int   hist [0:4095];
  int   k  = 0;
  int   zc = 0;
  int   exp_vc = 0;
  int   dut_vc = 0;

  // Edge count and the reset values seen at the last three edges.
  always @(posedge clock) begin
    cyc    <= cyc + 1;
    rst_sh <= {rst_sh[1:0], rst};
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: gradient from the pixel history, with A/B one frame-row back.
  task automatic drive(input bit r, input int v, input int h, input int p);
    exp_t e;
    int a, b, c, gx, gy, ax, ay;
    bit m;
    rst      = r;
    in_vcnt  = VB'(v);
    in_hcnt  = HB'(h);
    in_pixel = BW'(p);
    hist[k]  = p;
    if (r) zc = 0;
    m = !r && v >= 1 && h >= 1 && v < IH && h < IW && zc >= 2;
    e.due = cyc + 3;
    e.v = v;
    e.h = h;
    e.mag = 0;
    e.dir = 0;
    e.valid = 0;
    if (m) begin
      a  = hist[k-FW-1];
      b  = hist[k-FW];
      c  = hist[k-1];
      gx = (b + p) - (a + c);
      gy = (c + p) - (a + b);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      e.mag = ax + ay;
      if (gx == 0 && gy == 0)      e.dir = 0;
      else if (gx >= 0 && gy >= 0) e.dir = (ax > ay) ? 0 : 1;
      else if (gx < 0 && gy >= 0)  e.dir = (ay >= ax) ? 2 : 3;
      else if (gx < 0)             e.dir = (ax > ay) ? 4 : 5;
      else                         e.dir = (ay >= ax) ? 6 : 7;
      e.valid = (e.mag >= TH) ? 1 : 0;
    end
    if (!r && h == 0 && zc < 2) zc++;
    sb.push_back(e);
    k++;
  endtask

  function automatic int pix(input int pat, input int v, input int h);
    if (v >= IH || h >= IW) return int'($urandom_range(0, 255));
    case (pat)
      0:       return 100;
      1:       return (h < 4) ? 0 : 200;
      2:       return (v < 3) ? 50 : 10;
      3:       return (h < 4) ? 0 : 7;
      4:       return (h < 4) ? 0 : 8;
      6:       return int'($urandom_range(0, 12));
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: every cycle is an output; pop the entry due now and compare.
  initial begin
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        bit   z;
        e = sb.pop_front();
        z = (rst_sh != 3'b000);
        chk("due_cycle", cyc, e.due);
        chk("out_mag",   int'(out_mag),   z ? 0 : e.mag);
        chk("out_dir",   int'(out_dir),   z ? 0 : e.dir);
        chk("out_valid", int'(out_valid), z ? 0 : e.valid);
        chk("out_vcnt",  int'(out_vcnt),  z ? 0 : e.v);
        chk("out_hcnt",  int'(out_hcnt),  z ? 0 : e.h);
        if (!z && e.valid != 0) exp_vc++;
        if (out_valid) dut_vc++;
        $display("tx cyc=%0d v=%0d h=%0d mag=%0d dir=%0d valid=%0d", cyc,
                 out_vcnt, out_hcnt, out_mag, out_dir, out_valid);
      end
    end
  end

  // Stimulus: continuous raster of frames with a reset pulse at start and mid-frame.
  initial begin
    int  pats [10] = '{0, 1, 1, 2, 3, 4, 5, 6, 7, 5};
    bit  first;
    bit  r;
    int  drain;
    first = 1'b1;
    rst = 1'b1;
    in_pixel = '0;
    in_vcnt = '0;
    in_hcnt = '0;
    for (int f = 0; f < 10; f++) begin
      for (int v = 0; v < FH; v++) begin
        for (int h = 0; h < FW; h++) begin
          r = (f == 0 && v == 0 && h < 4) || (f == 8 && v == 3 && h == 2);
          if (!first) begin
            @(posedge clock);
            #1;
          end
          first = 1'b0;
          drive(r, v, h, pix(pats[f], v, h));
        end
      end
    end
    drain = 0;
    while (sb.size() > 0 && drain < 20) begin
      @(posedge clock);
      drain++;
    end
    @(negedge clock);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("valid_count", dut_vc, exp_vc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
